wormhole_alloc3: RTL and testbench

Switch allocator for the three-port corner router node: ports 0 and 1 are the mesh neighbours, port 2 is local. Each cycle it routes the head flit at every input FIFO by dimension-order XY routing and arbitrates each idle output round-robin among contending inputs. It then locks the output to the winner for the whole packet (wormhole), driving FIFO pops and link sends.

---
 rtl/wormhole_alloc3_pkg.sv | 44 ++++
 rtl/wormhole_alloc3_if.sv | 36 +++
 rtl/wormhole_alloc3_arb.sv | 34 +++
 rtl/wormhole_alloc3.sv | 151 +++++++++++++++
 tb/tb_wormhole_alloc3.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wormhole_alloc3_pkg.sv
// Shared definitions for the three-port wormhole allocator: port indices,
// flit field layout, per-output state encoding and routing helpers.
package router_pkg;

  localparam logic [1:0] PORT_0     = 2'd0;
  localparam logic [1:0] PORT_1     = 2'd1;
  localparam logic [1:0] PORT_LOCAL = 2'd2;

  // Header flit layout: length in [15:8], destination {X,Y} in [7:0]
  localparam int LEN_MSB  = 15;
  localparam int LEN_LSB  = 8;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 0;
  localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;
  localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} out_state_t;

  // Dimension-order routing: finish X first (port 0), then Y (port 1).
  function automatic logic [1:0] xy_route(input logic [ADDR_W-1:0] dest,
                                          input logic [3:0] node_x,
                                          input logic [3:0] node_y);
    logic [1:0] port;
    if (dest == {node_x, node_y})  port = PORT_LOCAL;
    else if (dest[7:4] != node_x)  port = PORT_0;
    else                           port = PORT_1;
    return port;
  endfunction

  // A zero length field still carries the header flit itself.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

  // (p + k) mod 3 for p in 0..2, k in 0..3
  function automatic logic [1:0] port_add(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= 3'd6)      s = s - 3'd6;
    else if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/wormhole_alloc3_if.sv
// Allocator-side bundle: input FIFO heads, downstream backpressure, the
// per-output mux select / send strobes, input pops and observability taps.
interface wormhole_alloc3_if;
  import router_pkg::*;

  // Handshake: a flit moves on output o exactly when send[o] is high, which
  // requires a flit at the owner's head (head_valid) and a ready downstream
  // (~buffer_full_in[o]); pop[i] is the same transfer seen from input i.
  logic [2:0]             head_valid;
  logic [2:0][ADDR_W-1:0] head_addr;
  logic [2:0][LEN_W-1:0]  head_len;
  logic [2:0]             buffer_full_in;
  logic [2:0][1:0]        out_sel;
  logic [2:0]             send;
  logic [2:0]             pop;
  logic                   route_err;

  logic [2:0]             dbg_busy;
  logic [2:0][LEN_W-1:0]  dbg_remaining;
  logic [2:0][1:0]        dbg_rr_ptr;
  logic [2:0]             dbg_drop;
  logic [2:0][2:0]        dbg_grant;

  modport master (
    output head_valid, head_addr, head_len, buffer_full_in,
    input  out_sel, send, pop, route_err,
    input  dbg_busy, dbg_remaining, dbg_rr_ptr, dbg_drop, dbg_grant
  );

  modport slave (
    input  head_valid, head_addr, head_len, buffer_full_in,
    output out_sel, send, pop, route_err,
    output dbg_busy, dbg_remaining, dbg_rr_ptr, dbg_drop, dbg_grant
  );

endinterface

// File: rtl/wormhole_alloc3_arb.sv
// Three-way round-robin arbiter: priority starts just after the pointer and
// wraps so the previous winner is considered last.
module rr_arbiter3
  import router_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] c1, c2, c3;

  always_comb begin
    c1  = port_add(ptr, 2'd1);
    c2  = port_add(ptr, 2'd2);
    c3  = (ptr > 2'd2) ? 2'd0 : ptr;
    idx = 2'd0;
    any = 1'b0;
    if (req[c1]) begin
      idx = c1;
      any = 1'b1;
    end else if (req[c2]) begin
      idx = c2;
      any = 1'b1;
    end else if (req[c3]) begin
      idx = c3;
      any = 1'b1;
    end
    gnt = any ? (3'b001 << idx) : 3'b000;
  end

endmodule

// File: rtl/wormhole_alloc3.sv
// Switch allocator for a three-port corner node: XY routing, per-output
// round-robin grant and wormhole lock, plus a per-input U-turn discard path.
module wormhole_alloc3
  import router_pkg::*;
#(
  parameter int NODE_X = 0,
  parameter int NODE_Y = 0
) (
  input logic             clk,
  input logic             rst,
  wormhole_alloc3_if.slave bus
);

  localparam logic [3:0] NX = 4'(NODE_X);
  localparam logic [3:0] NY = 4'(NODE_Y);

  out_state_t       state_q [3];
  out_state_t       state_d [3];
  logic [1:0]       owner_q [3];
  logic [1:0]       owner_d [3];
  logic [LEN_W-1:0] rem_q   [3];
  logic [LEN_W-1:0] rem_d   [3];
  logic [1:0]       rr_q    [3];
  logic [1:0]       rr_d    [3];

  logic [2:0]       drop_q, drop_d;
  logic [LEN_W-1:0] drop_rem_q [3];
  logic [LEN_W-1:0] drop_rem_d [3];
  logic             err_q, err_d;

  logic [1:0] route [3];
  logic [2:0] uturn, owns, drop_start;
  logic [2:0] req     [3];
  logic [2:0] gnt     [3];
  logic [1:0] gnt_idx [3];
  logic [2:0] gnt_any;
  logic [2:0] send, pop;

  // An input holding a lock or discarding never requests another output.
  always_comb begin
    owns = '0;
    for (int o = 0; o < 3; o++)
      if (state_q[o] == BUSY) owns[owner_q[o]] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      route[i]      = xy_route(bus.head_addr[i], NX, NY);
      uturn[i]      = (route[i] == 2'(i));
      drop_start[i] = bus.head_valid[i] & uturn[i] & ~owns[i] & ~drop_q[i];
    end
    for (int o = 0; o < 3; o++) begin
      req[o] = '0;
      for (int i = 0; i < 3; i++)
        req[o][i] = bus.head_valid[i] & (route[i] == 2'(o)) & ~uturn[i]
                    & ~owns[i] & ~drop_q[i];
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_arb
    rr_arbiter3 u_arb (
      .req (req[g]),
      .ptr (rr_q[g]),
      .gnt (gnt[g]),
      .idx (gnt_idx[g]),
      .any (gnt_any[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < 3; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= 2'd0;
        rem_q[o]   <= '0;
        rr_q[o]    <= 2'd0;
      end
      for (int i = 0; i < 3; i++) drop_rem_q[i] <= '0;
      drop_q <= '0;
      err_q  <= 1'b0;
    end else begin
      for (int o = 0; o < 3; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rem_q[o]   <= rem_d[o];
        rr_q[o]    <= rr_d[o];
      end
      for (int i = 0; i < 3; i++) drop_rem_q[i] <= drop_rem_d[i];
      drop_q <= drop_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    for (int o = 0; o < 3; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rem_d[o]   = rem_q[o];
      rr_d[o]    = rr_q[o];
      if (state_q[o] == IDLE) begin
        if (gnt_any[o]) begin
          state_d[o] = BUSY;
          owner_d[o] = gnt_idx[o];
          rem_d[o]   = eff_len(bus.head_len[gnt_idx[o]]);
        end
      end else if (send[o]) begin
        rem_d[o] = rem_q[o] - LEN_W'(1);
        if (rem_q[o] == LEN_W'(1)) begin
          state_d[o] = IDLE;
          rr_d[o]    = owner_q[o];
        end
      end
    end
    drop_d = drop_q;
    for (int i = 0; i < 3; i++) begin
      drop_rem_d[i] = drop_rem_q[i];
      if (drop_start[i]) begin
        drop_d[i]     = 1'b1;
        drop_rem_d[i] = eff_len(bus.head_len[i]);
      end else if (drop_q[i] && bus.head_valid[i]) begin
        drop_rem_d[i] = drop_rem_q[i] - LEN_W'(1);
        if (drop_rem_q[i] == LEN_W'(1)) drop_d[i] = 1'b0;
      end
    end
    err_d = err_q | (|drop_start);
  end

  always_comb begin
    send = '0;
    pop  = '0;
    for (int o = 0; o < 3; o++)
      send[o] = (state_q[o] == BUSY) & bus.head_valid[owner_q[o]]
                & ~bus.buffer_full_in[o];
    for (int o = 0; o < 3; o++)
      if (send[o]) pop[owner_q[o]] = 1'b1;
    for (int i = 0; i < 3; i++)
      if (drop_q[i] && bus.head_valid[i]) pop[i] = 1'b1;
  end

  always_comb begin
    bus.send      = send;
    bus.pop       = pop;
    bus.route_err = err_q;
    bus.dbg_drop  = drop_q;
    for (int o = 0; o < 3; o++) begin
      bus.out_sel[o]       = owner_q[o];
      bus.dbg_busy[o]      = (state_q[o] == BUSY);
      bus.dbg_remaining[o] = rem_q[o];
      bus.dbg_rr_ptr[o]    = rr_q[o];
      bus.dbg_grant[o]     = gnt[o];
    end
  end

endmodule

// File: tb/tb_wormhole_alloc3.sv
// Bench for wormhole_alloc3 at node (1,1): directed scenarios with exact
// cycle expectations, then random traffic against a packet-level model.
module tb_wormhole_alloc3;

  localparam logic [3:0] NX = 4'd1;
  localparam logic [3:0] NY = 4'd1;

  typedef struct packed {
    logic [7:0]  dest;
    logic [7:0]  len;
    logic [7:0]  lenf;
    logic [15:0] tag;
    logic [7:0]  idx;
  } flit_t;

  logic clk;
  logic rst_n;

  wormhole_alloc3_if bus();

  wormhole_alloc3 #(.NODE_X(1), .NODE_Y(1)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, required $finish");
    $fatal(1);
  end

  // ---------------- model state ----------------
  flit_t       in_q [3][$];
  logic [15:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          wait_cnt [3];
  int          gap_max = 0;
  bit          rand_full = 0;
  logic [2:0]  bf_force = '0;
  logic [2:0]  pop_seen;
  bit          active [3];
  int          cur_in [3];
  bit          was_end [3];
  bit          err_exp;
  int          tag_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_route(input logic [7:0] d);
    if (d[7:4] == NX && d[3:0] == NY) return 2'd2;
    if (d[7:4] != NX) return 2'd0;
    return 2'd1;
  endfunction

  function automatic int qtotal();
    int n = 0;
    for (int i = 0; i < 3; i++) n += in_q[i].size();
    return n;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      in_q[i].delete();
      wait_cnt[i] = 0;
      active[i]   = 0;
      cur_in[i]   = 0;
      was_end[i]  = 0;
    end
    exp_q.delete();
    pop_seen = '0;
    err_exp  = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_pkt(input int i, input logic [7:0] dest, input logic [7:0] len);
    flit_t f;
    int n;
    n = (len == 8'd0) ? 1 : int'(len);
    if (in_q[i].size() == 0) wait_cnt[i] = int'($urandom_range(0, gap_max));
    tag_cnt++;
    for (int k = 0; k < n; k++) begin
      f.dest = dest;
      f.len  = len;
      f.lenf = 8'(n);
      f.tag  = 16'(tag_cnt);
      f.idx  = 8'(k);
      in_q[i].push_back(f);
    end
    if (ref_route(dest) != 2'(i)) exp_q.push_back(16'(tag_cnt));
  endtask

  task automatic apply_pops();
    for (int i = 0; i < 3; i++)
      if (pop_seen[i] && in_q[i].size() > 0) begin
        void'(in_q[i].pop_front());
        if (in_q[i].size() > 0) wait_cnt[i] = int'($urandom_range(0, gap_max));
      end
    pop_seen = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < 3; i++) begin
      if (in_q[i].size() > 0) begin
        bus.head_addr[i]  = in_q[i][0].dest;
        bus.head_len[i]   = in_q[i][0].len;
        bus.head_valid[i] = (wait_cnt[i] == 0);
        if (wait_cnt[i] > 0) wait_cnt[i]--;
      end else begin
        bus.head_addr[i]  = '0;
        bus.head_len[i]   = '0;
        bus.head_valid[i] = 1'b0;
      end
    end
    bus.buffer_full_in = rand_full ? (3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7)))
                                   : bf_force;
  endtask

  // ---------------- scoreboard ----------------
  task automatic model_check();
    logic [2:0] sent_by;
    bit         ends [3];
    int         i;
    int         found;
    flit_t      f;
    sent_by = '0;
    for (int o = 0; o < 3; o++) begin
      ends[o] = 0;
      if (was_end[o]) check($sformatf("bubble_o%0d", o), 32'(bus.send[o]), 32'(0));
      if (bus.send[o]) begin
        i = int'(bus.out_sel[o]);
        check($sformatf("send_full_o%0d", o), 32'(bus.buffer_full_in[o]), 32'(0));
        if (i <= 2 && in_q[i].size() > 0) begin
          f = in_q[i][0];
          check($sformatf("send_hv_o%0d", o), 32'(bus.head_valid[i]), 32'(1));
          check($sformatf("send_pop_o%0d", o), 32'(bus.pop[i]), 32'(1));
          check($sformatf("send_route_o%0d", o), 32'(ref_route(f.dest)), 32'(o));
          if (active[o]) check($sformatf("contig_o%0d", o), 32'(i), 32'(cur_in[o]));
          else           check($sformatf("pkt_start_o%0d", o), 32'(f.idx), 32'(0));
          sent_by[i] = 1'b1;
          if (f.idx == f.lenf - 8'd1) begin
            ends[o]   = 1;
            active[o] = 0;
            found     = -1;
            foreach (exp_q[k]) if (exp_q[k] == f.tag && found < 0) found = k;
            check("sb_tag_expected", 32'(found >= 0), 32'(1));
            if (found >= 0) exp_q.delete(found);
          end else begin
            active[o] = 1;
            cur_in[o] = i;
          end
        end else begin
          check($sformatf("send_src_o%0d", o), 32'(i), 32'(99));
        end
      end
    end
    for (int o = 0; o < 3; o++) was_end[o] = ends[o];
    for (int k = 0; k < 3; k++)
      if (bus.pop[k] && !sent_by[k]) begin
        check($sformatf("drop_hv_i%0d", k), 32'(bus.head_valid[k]), 32'(1));
        if (in_q[k].size() > 0)
          check($sformatf("drop_route_i%0d", k), 32'(ref_route(in_q[k][0].dest)), 32'(k));
        else
          check($sformatf("drop_nonempty_i%0d", k), 32'(in_q[k].size()), 32'(1));
        err_exp = 1;
      end
    pop_seen = bus.pop;
    if (err_exp) check("route_err_sticky", 32'(bus.route_err), 32'(1));
  endtask

  // One cycle: inputs change just after the rising edge, outputs are
  // checked on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    apply_pops();
    drive();
    @(negedge clk);
    model_check();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int budget;
    int pi;
    rst_n = 1'b0;
    clear_model();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.dbg_busy), 32'(0));
    check("rst_out_sel", 32'(bus.out_sel), 32'(0));
    check("rst_send", 32'(bus.send), 32'(0));
    check("rst_pop", 32'(bus.pop), 32'(0));
    check("rst_route_err", 32'(bus.route_err), 32'(0));
    check("rst_rr", 32'(bus.dbg_rr_ptr), 32'(0));
    rst_n = 1'b1;

    // Local delivery: 4 flits from input 0, one allocation cycle first
    push_pkt(0, 8'h11, 8'd4);
    step();
    check("t1_alloc_send", 32'(bus.send), 32'(0));
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_send", 32'(bus.send), 32'(3'b100));
      check("t1_pop", 32'(bus.pop), 32'(3'b001));
      check("t1_sel", 32'(bus.out_sel[2]), 32'(0));
    end
    step();
    check("t1_idle", 32'(bus.dbg_busy), 32'(0));
    check("t1_rr", 32'(bus.dbg_rr_ptr[2]), 32'(0));

    // Contention on local output with pointer at 0: input 1 wins first
    for (int r = 0; r < 2; r++) begin
      push_pkt(0, 8'h11, 8'd3);
      push_pkt(1, 8'h11, 8'd3);
      step();
      check("t2_alloc_send", 32'(bus.send), 32'(0));
      for (int k = 0; k < 3; k++) begin
        step();
        check("t2_first_sel", 32'(bus.out_sel[2]), 32'(1));
        check("t2_first_pop", 32'(bus.pop), 32'(3'b010));
      end
      step();
      check("t2_bubble", 32'(bus.send), 32'(0));
      for (int k = 0; k < 3; k++) begin
        step();
        check("t2_second_sel", 32'(bus.out_sel[2]), 32'(0));
        check("t2_second_pop", 32'(bus.pop), 32'(3'b001));
      end
      step();
      check("t2_idle", 32'(bus.dbg_busy), 32'(0));
    end

    // Backpressure mid-packet freezes the counter
    push_pkt(0, 8'h11, 8'd6);
    step();
    step();
    check("t3_send_a", 32'(bus.send), 32'(3'b100));
    step();
    check("t3_send_b", 32'(bus.send), 32'(3'b100));
    bf_force = 3'b100;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_stall_send", 32'(bus.send), 32'(0));
      check("t3_stall_pop", 32'(bus.pop), 32'(0));
      check("t3_stall_rem", 32'(bus.dbg_remaining[2]), 32'(4));
    end
    bf_force = 3'b000;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t3_resume_send", 32'(bus.send), 32'(3'b100));
      check("t3_resume_rem", 32'(bus.dbg_remaining[2]), 32'(4 - k));
    end
    step();
    check("t3_idle", 32'(bus.dbg_busy), 32'(0));

    // Parallel: input 0 -> local, input 2 -> port 1
    push_pkt(0, 8'h11, 8'd3);
    push_pkt(2, 8'h13, 8'd3);
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_busy", 32'(bus.dbg_busy), 32'(3'b110));
      check("t4_send", 32'(bus.send), 32'(3'b110));
      check("t4_pop", 32'(bus.pop), 32'(3'b101));
      check("t4_sel1", 32'(bus.out_sel[1]), 32'(2));
      check("t4_sel2", 32'(bus.out_sel[2]), 32'(0));
    end
    step();
    check("t4_idle", 32'(bus.dbg_busy), 32'(0));

    // U-turn: input 0 toward X=2 is discarded
    check("t5_err_before", 32'(bus.route_err), 32'(0));
    push_pkt(0, 8'h21, 8'd2);
    step();
    check("t5_enter_pop", 32'(bus.pop), 32'(0));
    for (int k = 0; k < 2; k++) begin
      step();
      check("t5_pop", 32'(bus.pop), 32'(3'b001));
      check("t5_nosend", 32'(bus.send), 32'(0));
    end
    step();
    check("t5_done_pop", 32'(bus.pop), 32'(0));
    step();
    check("t5_err_sticky", 32'(bus.route_err), 32'(1));

    // Reset during flit 2 of 5
    push_pkt(1, 8'h11, 8'd5);
    step();
    step();
    check("t6_sel_before", 32'(bus.out_sel[2]), 32'(1));
    step();
    check("t6_flit2_send", 32'(bus.send), 32'(3'b100));
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(bus.dbg_busy), 32'(0));
    check("t6_rst_sel", 32'(bus.out_sel), 32'(0));
    check("t6_rst_send", 32'(bus.send), 32'(0));
    check("t6_rst_pop", 32'(bus.pop), 32'(0));
    check("t6_rst_rem", 32'(bus.dbg_remaining), 32'(0));
    check("t6_rst_err", 32'(bus.route_err), 32'(0));
    clear_model();
    step();
    step();
    rst_n = 1'b1;
    push_pkt(0, 8'h11, 8'd2);
    step();
    check("t6_alloc_send", 32'(bus.send), 32'(0));
    step();
    check("t6_first_send", 32'(bus.send), 32'(3'b100));
    check("t6_first_sel", 32'(bus.out_sel[2]), 32'(0));
    step();
    step();
    check("t6_idle", 32'(bus.dbg_busy), 32'(0));

    // Random traffic with gaps and backpressure
    gap_max   = 2;
    rand_full = 1;
    for (int s = 0; s < 600; s++) begin
      if ($urandom_range(0, 2) == 0) begin
        pi = int'($urandom_range(0, 2));
        if (in_q[pi].size() < 12)
          push_pkt(pi, {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))},
                   8'($urandom_range(0, 5)));
      end
      step();
    end
    rand_full = 0;
    budget = 0;
    while (qtotal() > 0 && budget < 3000) begin
      step();
      budget++;
    end
    step();
    check("drain_flits_left", 32'(qtotal()), 32'(0));
    check("sb_packets_left", 32'(exp_q.size()), 32'(0));
    check("drain_idle", 32'(bus.dbg_busy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
